bus_wait_ctrl: RTL and testbench
================================

# bus_wait_ctrl

Bus wait-state controller directly downstream of the 4510 mapper. Decodes the mapper's 20-bit `address_next` at the same clock edge the mapper registers it. Drives registered chip selects for RAM, ROM and I/O. Generates the `ready` signal that the core and mapper consume, inserting per-region wait states and stretching I/O cycles on an external wait request.

## Interface
- `RAM_WAITS`, default 0: wait cycles for RAM accesses (0–7).
- `ROM_WAITS`, default 1: wait cycles for ROM accesses (0–7).
- `IO_WAITS`, default 2: fixed wait cycles for I/O accesses (0–7).
- `IO_PAGE`, default 8'h0D: `address[19:12]` value selecting the 4 KB I/O page.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `address_next`  in  20  next physical address from the mapper (combinational).
- `we_next`  in  1  write strobe for the next access from the core.
- `ext_wait`  in  1  I/O device stretch request, active-high.
- `err_clr`  in  1  clears `bus_err`.
- `stats_clr`  in  1  clears `stall_count`.
- `ready`  out  1  current access completes this cycle.
- `ram_cs`, `rom_cs`, `io_cs`  out  1 each  registered chip selects for the current access.
- `we`  out  1  registered write strobe for the current access.
- `bus_err`  out  1  sticky flag: an unmapped address was accessed.
- `stall_count`  out  16  saturating count of cycles with `ready`=0.

## Operation
- Decode of `address_next`, highest priority first:
  - `[19:12]==IO_PAGE` selects I/O.
  - `[19:17]==0` selects RAM (0x00000–0x1FFFF).
  - `[19:17]==1` selects ROM (0x20000–0x3FFFF).
  - Anything else is unmapped: no chip select, 0 waits, sets `bus_err`.
- Access start: on a rising edge with `ready`=1, the block registers `ram_cs`/`rom_cs`/`io_cs`/`we` from the decode and loads a 3-bit wait counter.
- Chip selects and `we` hold their values while `ready`=0.
- FSM states:
  - RUN: `ready`=1. At an edge, an access with waits>0 loads count=waits−1 and goes to WAIT. An I/O access with `IO_WAITS`=0 goes to XWAIT. Otherwise the FSM stays in RUN.
  - WAIT: `ready`=0. The counter decrements each cycle. At count 0, a RAM/ROM access returns to RUN and an I/O access goes to XWAIT.
  - XWAIT: `ready`=~`ext_wait`, combinational. With `ext_wait`=0 it behaves exactly like RUN, including starting the next access at that edge.
- `ready` never depends combinationally on `address_next`. This prevents a loop through the mapper's `ready` mux.
- `bus_err`: set at the start of an unmapped access. Cleared by `err_clr`. When set and clear happen in the same cycle, set wins.

## Timing
- Reset values: FSM=RUN, `ready`=1, all chip selects=0, `we`=0, `bus_err`=0, `stall_count`=0.
- An access with N waits occupies N+1 cycles: `ready` is low for N cycles after the start edge and high in cycle N+1.
- An I/O access with `ext_wait` held high for K cycles in XWAIT occupies `IO_WAITS`+1+K cycles.
- Back-to-back zero-wait accesses give 1 access per cycle; `ready` stays high.
- Reset asserted mid-WAIT or mid-XWAIT: the next edge returns to RUN with `ready`=1 and chip selects cleared. The in-flight access is abandoned.
- Counter wrap is impossible: count loads only as waits−1 with waits ≥ 1.

## Configuration
- `BUS_WAIT_STATS_EN` defined:
  - `stall_count` increments on every clock with `ready`=0 and saturates at 16'hFFFF.
  - `stats_clr` clears it to 0; clear wins over a simultaneous increment.
- Not defined: `stall_count` is tied to 16'h0000, `stats_clr` is ignored, and no counter logic is synthesized.

## Test plan
- Reset, then `address_next`=0x01234 every cycle with default params -> `ready` stays 1, `ram_cs`=1 after the first edge, `stall_count`=0.
- Single access to 0x20000 (ROM_WAITS=1) -> `rom_cs`=1, `ready`=0 for exactly 1 cycle, then 1; `stall_count`=1 with stats enabled.
- Access to 0x0D020 with `ext_wait` high 3 cycles after the fixed waits -> `io_cs`=1 (I/O wins over RAM), `ready` low 2+3=5 cycles, `we` held throughout.
- Access to 0x80000, then `err_clr` pulse -> no chip select, `ready` stays 1, `bus_err`=1 until the clear, then 0. Set and clear in the same cycle leaves `bus_err`=1.
- Reset asserted during the second wait cycle of an I/O access -> next cycle `ready`=1, `io_cs`=0, FSM in RUN.
- `stall_count` preloaded near saturation via a long `ext_wait` stall -> holds at 16'hFFFF. `stats_clr` with a simultaneous stall -> 0. Without `BUS_WAIT_STATS_EN`, `stall_count` always 0.

Source files
------------

// File: rtl/bus_wait_ctrl.sv
// Bus wait-state controller behind the 4510 mapper: region decode, registered chip selects, ready generation.
// Optional stall statistics counter is built only when BUS_WAIT_STATS_EN is defined.
module bus_wait_ctrl #(
  parameter int unsigned RAM_WAITS = 0,
  parameter int unsigned ROM_WAITS = 1,
  parameter int unsigned IO_WAITS  = 2,
  parameter logic [7:0]  IO_PAGE   = 8'h0D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_next,
  input  logic        we_next,
  input  logic        ext_wait,
  input  logic        err_clr,
  input  logic        stats_clr,
  output logic        ready,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        io_cs,
  output logic        we,
  output logic        bus_err,
  output logic [15:0] stall_count
);
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_XWAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ram_cs_q, ram_cs_d;
  logic             rom_cs_q, rom_cs_d;
  logic             io_cs_q, io_cs_d;
  logic             we_q, we_d;
  logic             bus_err_q, bus_err_d;

  logic             dec_io, dec_ram, dec_rom, dec_unmapped;
  logic [CNT_W-1:0] dec_waits;

  // Region decode of the mapper's next address; the I/O page overrides RAM
  always_comb begin
    dec_io       = (address_next[19:12] == IO_PAGE);
    dec_ram      = !dec_io && (address_next[19:17] == 3'd0);
    dec_rom      = !dec_io && (address_next[19:17] == 3'd1);
    dec_unmapped = !(dec_io || dec_ram || dec_rom);
    dec_waits    = '0;
    if (dec_io)       dec_waits = CNT_W'(IO_WAITS);
    else if (dec_ram) dec_waits = CNT_W'(RAM_WAITS);
    else if (dec_rom) dec_waits = CNT_W'(ROM_WAITS);
  end

  // Low address bits only matter to the devices, not to the decode
  logic unused_addr_lo;
  assign unused_addr_lo = ^address_next[11:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ram_cs_q  <= 1'b0;
      rom_cs_q  <= 1'b0;
      io_cs_q   <= 1'b0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ram_cs_q  <= ram_cs_d;
      rom_cs_q  <= rom_cs_d;
      io_cs_q   <= io_cs_d;
      we_q      <= we_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state: a completing cycle starts the next access
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN, ST_XWAIT: begin
        if (ready) begin
          if (dec_waits != '0) begin
            state_d = ST_WAIT;
            cnt_d   = dec_waits - CNT_W'(1);
          end else if (dec_io) begin
            state_d = ST_XWAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = io_cs_q ? ST_XWAIT : ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs: ready from state and ext_wait only, never from address_next
  always_comb begin
    ready     = (state_q == ST_RUN) || ((state_q == ST_XWAIT) && !ext_wait);
    ram_cs_d  = ram_cs_q;
    rom_cs_d  = rom_cs_q;
    io_cs_d   = io_cs_q;
    we_d      = we_q;
    bus_err_d = bus_err_q && !err_clr;
    if (ready) begin
      ram_cs_d = dec_ram;
      rom_cs_d = dec_rom;
      io_cs_d  = dec_io;
      we_d     = we_next;
      if (dec_unmapped) bus_err_d = 1'b1;
    end
  end

  assign ram_cs  = ram_cs_q;
  assign rom_cs  = rom_cs_q;
  assign io_cs   = io_cs_q;
  assign we      = we_q;
  assign bus_err = bus_err_q;

`ifdef BUS_WAIT_STATS_EN
  logic [STAT_W-1:0] stall_count_q, stall_count_d;

  // Saturating stall counter; clear beats a simultaneous increment
  always_comb begin
    stall_count_d = stall_count_q;
    if (stats_clr)                                 stall_count_d = '0;
    else if (!ready && (stall_count_q != '1))      stall_count_d = stall_count_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stall_count      = STAT_W'(0);
`endif

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Randomized bench for bus_wait_ctrl against an access-level reference model.
module tb_bus_wait_ctrl;
  localparam int unsigned RAM_W = 0;
  localparam int unsigned ROM_W = 1;
  localparam int unsigned IO_W  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] address_next;
  logic        we_next, ext_wait, err_clr, stats_clr;
  logic        ready, ram_cs, rom_cs, io_cs, we, bus_err;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fixed wait cycles left, and whether the access ends in an ext_wait-controlled tail
  int fixed_left;
  bit io_tail;
  bit m_ram, m_rom, m_io, m_we, m_err;
  int m_stall;

  always #5 clk = ~clk;

  bus_wait_ctrl #(.RAM_WAITS(RAM_W), .ROM_WAITS(ROM_W), .IO_WAITS(IO_W), .IO_PAGE(8'h0D)) dut (
    .clk(clk), .reset(reset), .address_next(address_next), .we_next(we_next),
    .ext_wait(ext_wait), .err_clr(err_clr), .stats_clr(stats_clr),
    .ready(ready), .ram_cs(ram_cs), .rom_cs(rom_cs), .io_cs(io_cs), .we(we),
    .bus_err(bus_err), .stall_count(stall_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 unmapped, 1 RAM, 2 ROM, 3 I/O
  function automatic int region(input logic [19:0] a);
    if ((a >> 12) == 20'h0D) return 3;
    if (a < 20'h20000)       return 1;
    if (a < 20'h40000)       return 2;
    return 0;
  endfunction

  function automatic int waits_of(input int r);
    case (r)
      1: return int'(RAM_W);
      2: return int'(ROM_W);
      3: return int'(IO_W);
      default: return 0;
    endcase
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model at the rising edge
  task automatic step(input logic rst, input logic [19:0] a, input logic w, input logic ew,
                      input logic ec, input logic sc);
    bit exp_ready;
    int r;
    @(negedge clk);
    reset = rst; address_next = a; we_next = w; ext_wait = ew; err_clr = ec; stats_clr = sc;
    #1;
    exp_ready = (fixed_left == 0) && !(io_tail && ew);
    check_eq("ready",       32'(ready),       32'(exp_ready));
    check_eq("ram_cs",      32'(ram_cs),      32'(m_ram));
    check_eq("rom_cs",      32'(rom_cs),      32'(m_rom));
    check_eq("io_cs",       32'(io_cs),       32'(m_io));
    check_eq("we",          32'(we),          32'(m_we));
    check_eq("bus_err",     32'(bus_err),     32'(m_err));
    check_eq("stall_count", 32'(stall_count), 32'(m_stall));
    @(posedge clk);
    if (rst) begin
      fixed_left = 0; io_tail = 0;
      m_ram = 0; m_rom = 0; m_io = 0; m_we = 0; m_err = 0; m_stall = 0;
    end else begin
`ifdef BUS_WAIT_STATS_EN
      if (sc)                               m_stall = 0;
      else if (!exp_ready && m_stall < 65535) m_stall++;
`else
      m_stall = 0;
`endif
      if (exp_ready) begin
        r = region(a);
        fixed_left = waits_of(r);
        io_tail = (r == 3);
        m_ram = (r == 1); m_rom = (r == 2); m_io = (r == 3); m_we = w;
        m_err = (r == 0) || (m_err && !ec);
      end else begin
        if (fixed_left > 0) fixed_left--;
        m_err = m_err && !ec;
      end
    end
  endtask

  function automatic logic [19:0] rand_addr();
    logic [19:0] edges [7];
    edges = '{20'h1FFFF, 20'h20000, 20'h3FFFF, 20'h40000, 20'h0CFFF, 20'h0E000, 20'hFFFFF};
    case ($urandom_range(0, 5))
      0: return {8'h0D, 12'($urandom)};
      1: return 20'(17'($urandom));
      2: return 20'h20000 | 20'(17'($urandom));
      3: return 20'h40000 + 20'($urandom_range(0, 32'hBFFFF));
      4: return edges[$urandom_range(0, 6)];
      default: return 20'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; address_next = '0; we_next = 0; ext_wait = 0; err_clr = 0; stats_clr = 0;
    fixed_left = 0; io_tail = 0;
    m_ram = 0; m_rom = 0; m_io = 0; m_we = 0; m_err = 0; m_stall = 0;
    repeat (3) @(posedge clk);

    // Zero-wait RAM stream
    repeat (5) step(0, 20'h01234, 0, 0, 0, 0);
    // Single ROM access then idle RAM
    step(0, 20'h20000, 0, 0, 0, 0);
    repeat (3) step(0, 20'h00010, 0, 0, 0, 0);
    // I/O write with 3 cycles of external stretch after the fixed waits
    step(0, 20'h0D020, 1, 0, 0, 0);
    repeat (2) step(0, 20'h00000, 0, 0, 0, 0);
    repeat (3) step(0, 20'h00000, 0, 1, 0, 0);
    repeat (2) step(0, 20'h00000, 0, 0, 0, 0);
    // Unmapped access, sticky error, clear, and set-with-clear
    step(0, 20'h80000, 0, 0, 0, 0);
    repeat (2) step(0, 20'h00100, 0, 0, 0, 0);
    step(0, 20'h00100, 0, 0, 1, 0);
    step(0, 20'h80000, 0, 0, 1, 0);
    repeat (2) step(0, 20'h00100, 0, 0, 0, 0);
    step(0, 20'h00100, 0, 0, 1, 0);
    // Reset during second wait cycle of an I/O access
    step(0, 20'h0D000, 1, 1, 0, 0);
    step(0, 20'h00000, 0, 1, 0, 0);
    step(1, 20'h00000, 0, 1, 0, 0);
    repeat (2) step(0, 20'h00000, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), rand_addr(), 1'($urandom),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0));
    end

    // Long external stall drives the counter into saturation, then clear under stall
    step(0, 20'h0D100, 0, 1, 0, 1);
    for (int i = 0; i < 65540; i++) step(0, 20'h0D100, 0, 1, 0, 0);
    step(0, 20'h0D100, 0, 1, 0, 1);
    repeat (3) step(0, 20'h0D100, 0, 1, 0, 0);
    repeat (3) step(0, 20'h00200, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
